jtkiwi_shram_arb: RTL and testbench
===================================

JTKIWI_SHRAM_ARB -- requirements
Module: jtkiwi_shram_arb

Interface
REQ-001 Parameter AW, default 13, shared-RAM address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 lock  input  1  main-CPU exclusive ownership (mshramen); blocks sub-CPU grants while high.
REQ-006 m_cs, m_wrn  input  1 each  main-CPU request (level) and write strobe (active-low).
REQ-007 m_addr  input  AW  main-CPU address; m_din  input  DW  main-CPU write data.
REQ-008 m_dout  output  DW  main-CPU read data, registered; m_busy  output  1  wait request to main CPU.
REQ-009 s_cs, s_wrn, s_addr, s_din, s_dout, s_busy  same widths and directions as the m_* ports, for the sub CPU.
REQ-010 ram_addr  output  AW  registered; ram_din  output  DW  registered; ram_we  output  1  registered.
REQ-011 ram_dout  input  DW  synchronous RAM read data, valid one cycle after ram_addr.

Function
REQ-012 States: IDLE, GNT_M, GNT_S; exactly one state at a time.
REQ-013 Per requester: served flag; pending = cs & ~served; sub pending also requires ~lock.
REQ-014 busy = cs & ~served, combinational; busy is low whenever cs is low.
REQ-015 IDLE: if one requester is pending, enter its GNT state; if none is pending, stay in IDLE.
REQ-016 IDLE, both pending: grant the requester not served last (last_sub flag); last_sub updates on every grant.
REQ-017 Entering GNT_x: register ram_addr<=x_addr, ram_din<=x_din, ram_we<=~x_wrn; ram_we is high for exactly that one GNT cycle.
REQ-018 Leaving GNT_x: x_dout<=ram_dout (reads and writes alike); served_x<=1 only if x_cs is still high.
REQ-019 GNT_x exit: if the other requester is pending, enter its GNT state directly (back-to-back); otherwise enter IDLE.
REQ-020 Latency: x_cs sampled high in IDLE at edge N -> ram_addr valid after N -> x_dout valid and x_busy low after N+2.
REQ-021 served_x clears on any edge where x_cs is low; a new access needs cs low for at least one clk.
REQ-022 cs dropping during GNT_x: the RAM cycle completes, x_dout is updated, served_x stays 0.
REQ-023 lock rising during GNT_S: the current access completes; no further sub grant while lock is high; s_busy stays high.
REQ-024 lock never delays or blocks the main requester.
REQ-025 Outside GNT states, ram_we=0 and ram_addr/ram_din hold their last values.

Reset
REQ-026 rst_n low: state=IDLE, ram_we=0, ram_addr=0, ram_din=0, m_dout=0, s_dout=0, served flags=0, last_sub=0; applied asynchronously.
REQ-027 Reset mid-access aborts it with no partial write; ram_we falls immediately on rst_n assertion.
REQ-028 After rst_n release, the first tie goes to the sub CPU (last_sub=0 means main was served last).

Structure
REQ-029 The state encoding and the AW/DW defaults SHALL be defined as localparams in shared package jtkiwi_shram_pkg.
REQ-030 One sub-module, jtkiwi_shram_port, instantiated twice: served flag, busy, dout capture.
REQ-031 The arbiter FSM, tie-break logic and RAM-side registers stay in the top module; no memory is instantiated inside.

Verification
REQ-032 Main read of 0x0123 (RAM 0x5A), sub idle -> GNT_M for 1 cycle, m_dout=0x5A, m_busy low 2 cycles after m_cs.
REQ-033 Both request on the same edge after reset -> sub granted first, main back-to-back next cycle; ram_we stays 0 for reads.
REQ-034 Sub writes 0xA5 to 0x1FFF -> single-cycle ram_we with ram_addr=0x1FFF and ram_din=0xA5; main read of 0x1FFF then returns 0xA5.
REQ-035 lock=1, sub requests for 20 cycles -> no GNT_S, s_busy high; lock->0 -> sub served within 2 cycles.
REQ-036 m_cs held high 10 cycles -> exactly one grant; drop 1 cycle and reassert -> second grant.
REQ-037 rst_n asserted during GNT_S with a write -> ram_we low immediately, all outputs at reset values, no RAM content change.

Source files
------------

// File: rtl/jtkiwi_shram_pkg.sv
// Shared definitions for the main/sub CPU shared-RAM arbiter.
// Holds the default bus widths and the arbiter state encoding.
package jtkiwi_shram_pkg;

  localparam int SHRAM_AW = 13;
  localparam int SHRAM_DW = 8;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_GNT_M_ENC = 2'd1;
  localparam logic [1:0] ST_GNT_S_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    GNT_M = ST_GNT_M_ENC,
    GNT_S = ST_GNT_S_ENC
  } shram_state_t;

endpackage

// File: rtl/jtkiwi_shram_port.sv
// One requester port of the shared-RAM arbiter: served flag, busy
// (wait request) and capture of the RAM read data into the CPU-side register.
module jtkiwi_shram_port
  import jtkiwi_shram_pkg::*;
#(
  parameter int DW = SHRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          gnt,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          pending,
  output logic [DW-1:0] dout
);

  logic          served_q, served_d;
  logic          cap_q, cap_d;
  logic          cap_ok_q, cap_ok_d;
  logic [DW-1:0] dout_q, dout_d;

  // The RAM answers one cycle after the grant cycle, so the data capture
  // and the served flag land on the edge after the grant ends.
  always_comb begin
    cap_d    = gnt;
    cap_ok_d = gnt & cs;
    dout_d   = cap_q ? ram_dout : dout_q;
    served_d = cs & (served_q | (cap_q & cap_ok_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q <= 1'b0;
      cap_q    <= 1'b0;
      cap_ok_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      served_q <= served_d;
      cap_q    <= cap_d;
      cap_ok_q <= cap_ok_d;
      dout_q   <= dout_d;
    end
  end

  // An access still in flight must not be granted a second time.
  assign pending = cs & ~served_q & ~cap_q & ~gnt;
  assign busy    = cs & ~served_q;
  assign dout    = dout_q;

endmodule

// File: rtl/jtkiwi_shram_arb.sv
// Arbiter between the main and sub CPU for a single-port synchronous RAM.
// Round-robin on ties, main-CPU lock that excludes the sub CPU.
//
// state | meaning
// IDLE  | no RAM cycle issued this clock
// GNT_M | RAM cycle for the main CPU (address/data/we registered)
// GNT_S | RAM cycle for the sub CPU (address/data/we registered)
module jtkiwi_shram_arb
  import jtkiwi_shram_pkg::*;
#(
  parameter int AW = SHRAM_AW,
  parameter int DW = SHRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lock,
  input  logic          m_cs,
  input  logic          m_wrn,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_din,
  output logic [DW-1:0] m_dout,
  output logic          m_busy,
  input  logic          s_cs,
  input  logic          s_wrn,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          s_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  shram_state_t  state_q, state_d;
  logic          last_sub_q, last_sub_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;

  logic m_pend_raw, s_pend_raw;
  logic m_pend, s_pend;
  logic gnt_m, gnt_s;

  assign gnt_m  = (state_q == GNT_M);
  assign gnt_s  = (state_q == GNT_S);
  assign m_pend = m_pend_raw;
  assign s_pend = s_pend_raw & ~lock;

  jtkiwi_shram_port #(.DW(DW)) u_port_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (m_cs),
    .gnt      (gnt_m),
    .ram_dout (ram_dout),
    .busy     (m_busy),
    .pending  (m_pend_raw),
    .dout     (m_dout)
  );

  jtkiwi_shram_port #(.DW(DW)) u_port_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (s_cs),
    .gnt      (gnt_s),
    .ram_dout (ram_dout),
    .busy     (s_busy),
    .pending  (s_pend_raw),
    .dout     (s_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_sub_q <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_sub_q <= last_sub_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
    end
  end

  // last_sub_q=0 means main went last, so a tie favours the sub CPU.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m_pend && s_pend) state_d = last_sub_q ? GNT_M : GNT_S;
        else if (m_pend)      state_d = GNT_M;
        else if (s_pend)      state_d = GNT_S;
        else                  state_d = IDLE;
      end
      GNT_M:   state_d = s_pend ? GNT_S : IDLE;
      GNT_S:   state_d = m_pend ? GNT_M : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    last_sub_d = last_sub_q;
    case (state_d)
      GNT_M: begin
        ram_addr_d = m_addr;
        ram_din_d  = m_din;
        ram_we_d   = ~m_wrn;
        last_sub_d = 1'b0;
      end
      GNT_S: begin
        ram_addr_d = s_addr;
        ram_din_d  = s_din;
        ram_we_d   = ~s_wrn;
        last_sub_d = 1'b1;
      end
      default: begin
        ram_we_d = 1'b0;
      end
    endcase
  end

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Directed bench for the shared-RAM arbiter with a behavioural synchronous RAM.
module tb_jtkiwi_shram_arb;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          lock;
  logic          m_cs, m_wrn, s_cs, s_wrn;
  logic [AW-1:0] m_addr, s_addr;
  logic [DW-1:0] m_din, s_din;
  logic [DW-1:0] m_dout, s_dout;
  logic          m_busy, s_busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk;
  int n_fail;

  jtkiwi_shram_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lock     (lock),
    .m_cs     (m_cs),
    .m_wrn    (m_wrn),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_dout   (m_dout),
    .m_busy   (m_busy),
    .s_cs     (s_cs),
    .s_wrn    (s_wrn),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_dout   (s_dout),
    .s_busy   (s_busy),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: write on we, read data one cycle after address.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[13'h0123] = 8'h5A;
    mem[13'h0456] = 8'h3C;
    ram_dout = '0;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  typedef struct packed {
    logic          m_cs;
    logic          m_wrn;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic          s_cs;
    logic          s_wrn;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic          e_m_busy;
    logic          e_s_busy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [DW-1:0] e_m_dout;
    logic [DW-1:0] e_s_dout;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cs = 0; m_wrn = 1; m_addr = '0; m_din = '0;
    s_cs = 0; s_wrn = 1; s_addr = '0; s_din = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    lock = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  initial begin
    int cnt;
    int bad_we;
    int bad_busy;
    logic got;

    n_chk = 0;
    n_fail = 0;
    rst_n = 0;
    lock = 0;
    idle_inputs();

    vecs[0]  = '{1'b1, 1'b1, 13'h0123, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 13'h0123, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 13'h0123, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 13'h0123, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 13'h0123, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 13'h0123, 8'h00, 8'h5A, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 13'h0123, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 13'h0123, 8'h00, 8'h5A, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 13'h0123, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 13'h0123, 8'h00, 8'h5A, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h1FFF, 8'hA5, 1'b0, 1'b1, 1'b1, 13'h1FFF, 8'hA5, 8'h5A, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h1FFF, 8'hA5, 1'b0, 1'b1, 1'b0, 13'h1FFF, 8'hA5, 8'h5A, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h1FFF, 8'hA5, 1'b0, 1'b0, 1'b0, 13'h1FFF, 8'hA5, 8'h5A, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 13'h1FFF, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 13'h1FFF, 8'h00, 8'h5A, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 13'h1FFF, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 13'h1FFF, 8'h00, 8'h5A, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 13'h1FFF, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hA5, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 13'h1FFF, 8'h00, 1'b0, 1'b1, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hA5, 8'h00};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst ram_we",   {31'd0, ram_we}, 32'd0);
    chk("rst ram_addr", {19'd0, ram_addr}, 32'd0);
    chk("rst ram_din",  {24'd0, ram_din}, 32'd0);
    chk("rst m_dout",   {24'd0, m_dout}, 32'd0);
    chk("rst s_dout",   {24'd0, s_dout}, 32'd0);
    rst_n = 1;
    tick();

    // Main read latency, sub write, main readback
    for (int i = 0; i < 12; i++) begin
      m_cs = vecs[i].m_cs; m_wrn = vecs[i].m_wrn; m_addr = vecs[i].m_addr; m_din = vecs[i].m_din;
      s_cs = vecs[i].s_cs; s_wrn = vecs[i].s_wrn; s_addr = vecs[i].s_addr; s_din = vecs[i].s_din;
      tick();
      chk($sformatf("v%0d m_busy", i),   {31'd0, m_busy},   {31'd0, vecs[i].e_m_busy});
      chk($sformatf("v%0d s_busy", i),   {31'd0, s_busy},   {31'd0, vecs[i].e_s_busy});
      chk($sformatf("v%0d ram_we", i),   {31'd0, ram_we},   {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d ram_addr", i), {19'd0, ram_addr}, {19'd0, vecs[i].e_addr});
      chk($sformatf("v%0d ram_din", i),  {24'd0, ram_din},  {24'd0, vecs[i].e_din});
      chk($sformatf("v%0d m_dout", i),   {24'd0, m_dout},   {24'd0, vecs[i].e_m_dout});
      chk($sformatf("v%0d s_dout", i),   {24'd0, s_dout},   {24'd0, vecs[i].e_s_dout});
    end
    chk("mem 1FFF", {24'd0, mem[13'h1FFF]}, 32'h0000_00A5);

    // Lock does not hold off the main CPU
    lock = 1;
    m_cs = 1; m_wrn = 0; m_addr = 13'h0010; m_din = 8'h99;
    tick();
    chk("lock main we",   {31'd0, ram_we}, 32'd1);
    chk("lock main addr", {19'd0, ram_addr}, 32'h0010);
    tick(); tick();
    chk("lock main busy", {31'd0, m_busy}, 32'd0);
    m_cs = 0; m_wrn = 1;
    tick();

    // Lock keeps the sub CPU waiting, release grants it promptly
    s_cs = 1; s_wrn = 0; s_addr = 13'h0042; s_din = 8'h77;
    bad_we = 0; bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ram_we !== 1'b0) bad_we++;
      if (s_busy !== 1'b1) bad_busy++;
    end
    chk("lock sub we cycles",   bad_we, 0);
    chk("lock sub busy drops",  bad_busy, 0);
    lock = 0;
    got = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ram_we === 1'b1 && ram_addr === 13'h0042) got = 1;
    end
    chk("unlock sub grant", {31'd0, got}, 32'd1);
    tick(); tick();
    chk("unlock sub mem", {24'd0, mem[13'h0042]}, 32'h77);
    chk("unlock sub busy", {31'd0, s_busy}, 32'd0);
    s_cs = 0; s_wrn = 1;
    tick();

    // Held request gets one grant; drop and reassert gets another
    m_cs = 1; m_wrn = 0; m_addr = 13'h0020; m_din = 8'h11;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_we === 1'b1) cnt++;
    end
    chk("held grants", cnt, 1);
    m_cs = 0;
    tick();
    m_cs = 1; m_din = 8'h22;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ram_we === 1'b1) cnt++;
    end
    chk("regrant count", cnt, 1);
    chk("regrant mem", {24'd0, mem[13'h0020]}, 32'h22);
    m_cs = 0; m_wrn = 1;
    tick();

    // Simultaneous requests after reset: sub first, main back-to-back
    do_reset();
    m_cs = 1; m_wrn = 1; m_addr = 13'h0123;
    s_cs = 1; s_wrn = 1; s_addr = 13'h0456;
    tick();
    chk("tie first addr", {19'd0, ram_addr}, 32'h0456);
    chk("tie first we",   {31'd0, ram_we}, 32'd0);
    tick();
    chk("tie second addr", {19'd0, ram_addr}, 32'h0123);
    chk("tie second we",   {31'd0, ram_we}, 32'd0);
    tick();
    chk("tie s_dout", {24'd0, s_dout}, 32'h3C);
    chk("tie s_busy", {31'd0, s_busy}, 32'd0);
    chk("tie m_busy mid", {31'd0, m_busy}, 32'd1);
    tick();
    chk("tie m_dout", {24'd0, m_dout}, 32'h5A);
    chk("tie m_busy", {31'd0, m_busy}, 32'd0);
    idle_inputs();
    tick();

    // Reset in the middle of a sub write
    s_cs = 1; s_wrn = 0; s_addr = 13'h0030; s_din = 8'hEE;
    tick();
    chk("pre-rst we",   {31'd0, ram_we}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("async rst we",     {31'd0, ram_we}, 32'd0);
    chk("async rst addr",   {19'd0, ram_addr}, 32'd0);
    chk("async rst din",    {24'd0, ram_din}, 32'd0);
    chk("async rst m_dout", {24'd0, m_dout}, 32'd0);
    chk("async rst s_dout", {24'd0, s_dout}, 32'd0);
    tick();
    chk("rst no write", {24'd0, mem[13'h0030]}, 32'd0);
    idle_inputs();
    rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
